// File: rtl/pll_reset_sequencer.sv
// PLL bring-up sequencer: drives PLL resetn/clkout0en and holds the
// PLL clock domain in reset until lock has been stable and the clock is on.
module pll_reset_sequencer #(
    parameter int RESET_CYCLES  = 16,
    parameter int LOCK_TIMEOUT  = 4096,
    parameter int STABLE_CYCLES = 256,
    parameter int ENABLE_CYCLES = 8,
    parameter int MAX_RETRIES   = 3,
    parameter int CNT_W         = 16
) (
    input  logic       clkin,
    input  logic       reset,
    input  logic       lock,
    input  logic       relock_req,
    output logic       pll_resetn,
    output logic       pll_clkout0en,
    output logic       sys_rst,
    output logic       ready,
    output logic       fail,
    output logic [2:0] state,
    output logic [3:0] retry_cnt
);

    typedef enum logic [2:0] {
        RESET_PLL = 3'd0,
        WAIT_LOCK = 3'd1,
        STABLE    = 3'd2,
        ENABLE    = 3'd3,
        RUN       = 3'd4,
        FAIL      = 3'd5
    } state_t;

    localparam logic [CNT_W-1:0] RST_LAST = CNT_W'(RESET_CYCLES - 1);
    localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'(LOCK_TIMEOUT - 1);
    localparam logic [CNT_W-1:0] STB_LAST = CNT_W'(STABLE_CYCLES - 1);
    localparam logic [CNT_W-1:0] ENA_LAST = CNT_W'(ENABLE_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [3:0]       MAX_R    = 4'(MAX_RETRIES);

    state_t           cur;
    state_t           nxt;
    logic [CNT_W-1:0] cnt;
    logic [3:0]       retry_nxt;
    logic             lock_m;
    logic             lock_s;

    assign state = cur;

    always_ff @(posedge clkin) begin
        if (reset) begin
            lock_m <= 1'b0;
            lock_s <= 1'b0;
        end else begin
            lock_m <= lock;
            lock_s <= lock_m;
        end
    end

    always_comb begin
        nxt       = cur;
        retry_nxt = retry_cnt;
        case (cur)
            RESET_PLL: begin
                if (cnt == RST_LAST) nxt = WAIT_LOCK;
            end
            WAIT_LOCK: begin
                // lock wins over a coincident timeout
                if (lock_s) begin
                    nxt = STABLE;
                end else if (cnt == TMO_LAST) begin
                    if (retry_cnt == MAX_R) begin
                        nxt = FAIL;
                    end else begin
                        nxt = RESET_PLL;
                        if (retry_cnt != 4'hf) retry_nxt = retry_cnt + 4'd1;
                    end
                end
            end
            STABLE: begin
                if (!lock_s) nxt = WAIT_LOCK;
                else if (cnt == STB_LAST) nxt = ENABLE;
            end
            ENABLE: begin
                if (!lock_s) begin
                    nxt = RESET_PLL;
                end else if (cnt == ENA_LAST) begin
                    nxt       = RUN;
                    retry_nxt = 4'd0;
                end
            end
            RUN: begin
                if (!lock_s || relock_req) nxt = RESET_PLL;
            end
            FAIL: begin
                if (relock_req) begin
                    nxt       = RESET_PLL;
                    retry_nxt = 4'd0;
                end
            end
            default: nxt = RESET_PLL;
        endcase
    end

    // outputs are registered from the next state so they move with it
    always_ff @(posedge clkin) begin
        if (reset) begin
            cur           <= RESET_PLL;
            cnt           <= '0;
            retry_cnt     <= 4'd0;
            pll_resetn    <= 1'b0;
            pll_clkout0en <= 1'b0;
            sys_rst       <= 1'b1;
            ready         <= 1'b0;
            fail          <= 1'b0;
        end else begin
            cur           <= nxt;
            retry_cnt     <= retry_nxt;
            cnt           <= (nxt != cur) ? '0 : cnt + CNT_ONE;
            pll_resetn    <= nxt inside {WAIT_LOCK, STABLE, ENABLE, RUN};
            pll_clkout0en <= nxt inside {ENABLE, RUN};
            sys_rst       <= (nxt != RUN);
            ready         <= (nxt == RUN);
            fail          <= (nxt == FAIL);
        end
    end

endmodule

// File: tb/tb_pll_reset_sequencer.sv
// Directed bench for pll_reset_sequencer with short phase parameters.
module tb_pll_reset_sequencer;

    logic       clk = 1'b0;
    logic       reset;
    logic       lock;
    logic       relock_req;
    logic       pll_resetn;
    logic       pll_clkout0en;
    logic       sys_rst;
    logic       ready;
    logic       fail;
    logic [2:0] state;
    logic [3:0] retry_cnt;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    pll_reset_sequencer #(
        .RESET_CYCLES (4),
        .LOCK_TIMEOUT (20),
        .STABLE_CYCLES(8),
        .ENABLE_CYCLES(2),
        .MAX_RETRIES  (2),
        .CNT_W        (16)
    ) dut (
        .clkin        (clk),
        .reset        (reset),
        .lock         (lock),
        .relock_req   (relock_req),
        .pll_resetn   (pll_resetn),
        .pll_clkout0en(pll_clkout0en),
        .sys_rst      (sys_rst),
        .ready        (ready),
        .fail         (fail),
        .state        (state),
        .retry_cnt    (retry_cnt)
    );

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    // leaves the bench at the negedge of cycle 0 after reset release
    task automatic start_bringup(input logic lk);
        reset      = 1'b1;
        lock       = lk;
        relock_req = 1'b0;
        tick(1);
        reset = 1'b0;
    endtask

    task automatic test_reset();
        reset      = 1'b1;
        lock       = 1'b1;
        relock_req = 1'b0;
        tick(3);
        checks++;
        if (state !== 3'd0 || retry_cnt !== 4'd0) begin
            errors++;
            $display("FAIL reset_state st=%0d rc=%0d exp st=0 rc=0", state, retry_cnt);
        end
        checks++;
        if ({pll_resetn, pll_clkout0en, sys_rst, ready, fail} !== 5'b00100) begin
            errors++;
            $display("FAIL reset_outputs got=%b exp=00100",
                     {pll_resetn, pll_clkout0en, sys_rst, ready, fail});
        end
    endtask

    task automatic test_happy_path();
        logic [2:0] exp_st;
        logic [3:0] exp_o;
        start_bringup(1'b1);
        for (int c = 0; c <= 17; c++) begin
            if (c < 4) exp_st = 3'd0;
            else if (c == 4) exp_st = 3'd1;
            else if (c < 13) exp_st = 3'd2;
            else if (c < 15) exp_st = 3'd3;
            else exp_st = 3'd4;
            exp_o = {c >= 4, c >= 13, c < 15, c >= 15};
            checks++;
            if (state !== exp_st) begin
                errors++;
                $display("FAIL happy_state cyc=%0d got=%0d exp=%0d", c, state, exp_st);
            end
            checks++;
            if ({pll_resetn, pll_clkout0en, sys_rst, ready} !== exp_o) begin
                errors++;
                $display("FAIL happy_outputs cyc=%0d got=%b exp=%b", c,
                         {pll_resetn, pll_clkout0en, sys_rst, ready}, exp_o);
            end
            tick(1);
        end
    endtask

    task automatic test_lock_glitch();
        start_bringup(1'b1);
        tick(8);
        lock = 1'b0;
        tick(1);
        lock = 1'b1;
        tick(1);
        checks++;
        if (state !== 3'd2) begin
            errors++;
            $display("FAIL glitch_still_stable got=%0d exp=2", state);
        end
        tick(1);
        checks++;
        if (state !== 3'd1 || retry_cnt !== 4'd0) begin
            errors++;
            $display("FAIL glitch_wait_lock st=%0d rc=%0d exp st=1 rc=0", state, retry_cnt);
        end
        tick(1);
        checks++;
        if (state !== 3'd2) begin
            errors++;
            $display("FAIL glitch_restable got=%0d exp=2", state);
        end
        tick(9);
        checks++;
        if (state !== 3'd3 || ready !== 1'b0) begin
            errors++;
            $display("FAIL glitch_pre_ready st=%0d rdy=%b exp st=3 rdy=0", state, ready);
        end
        tick(1);
        checks++;
        if (state !== 3'd4 || ready !== 1'b1 || retry_cnt !== 4'd0) begin
            errors++;
            $display("FAIL glitch_ready st=%0d rdy=%b rc=%0d exp 4/1/0", state, ready, retry_cnt);
        end
    endtask

    task automatic test_timeout_fail();
        int bad;
        start_bringup(1'b0);
        tick(23);
        checks++;
        if (state !== 3'd1 || retry_cnt !== 4'd0) begin
            errors++;
            $display("FAIL tmo_win1 st=%0d rc=%0d exp st=1 rc=0", state, retry_cnt);
        end
        tick(1);
        checks++;
        if (state !== 3'd0 || retry_cnt !== 4'd1) begin
            errors++;
            $display("FAIL tmo_retry1 st=%0d rc=%0d exp st=0 rc=1", state, retry_cnt);
        end
        tick(23);
        checks++;
        if (state !== 3'd1 || retry_cnt !== 4'd1) begin
            errors++;
            $display("FAIL tmo_win2 st=%0d rc=%0d exp st=1 rc=1", state, retry_cnt);
        end
        tick(1);
        checks++;
        if (state !== 3'd0 || retry_cnt !== 4'd2) begin
            errors++;
            $display("FAIL tmo_retry2 st=%0d rc=%0d exp st=0 rc=2", state, retry_cnt);
        end
        tick(23);
        checks++;
        if (state !== 3'd1) begin
            errors++;
            $display("FAIL tmo_win3 got=%0d exp=1", state);
        end
        tick(1);
        checks++;
        if (state !== 3'd5 || fail !== 1'b1 || pll_resetn !== 1'b0 ||
            sys_rst !== 1'b1 || retry_cnt !== 4'd2) begin
            errors++;
            $display("FAIL tmo_fail st=%0d fail=%b rn=%b srst=%b rc=%0d exp 5/1/0/1/2",
                     state, fail, pll_resetn, sys_rst, retry_cnt);
        end
        bad = 0;
        repeat (100) begin
            tick(1);
            if (state !== 3'd5 || fail !== 1'b1 || pll_resetn !== 1'b0) bad++;
        end
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL tmo_hold bad_cycles=%0d exp=0", bad);
        end
    endtask

    task automatic test_loss_in_run();
        start_bringup(1'b1);
        tick(16);
        lock = 1'b0;
        tick(2);
        checks++;
        if (ready !== 1'b1 || sys_rst !== 1'b0) begin
            errors++;
            $display("FAIL loss_early rdy=%b srst=%b exp rdy=1 srst=0", ready, sys_rst);
        end
        tick(1);
        checks++;
        if ({pll_resetn, pll_clkout0en, sys_rst, ready} !== 4'b0010 || state !== 3'd0) begin
            errors++;
            $display("FAIL loss_edge3 outs=%b st=%0d exp outs=0010 st=0",
                     {pll_resetn, pll_clkout0en, sys_rst, ready}, state);
        end
        for (int k = 0; k < 3; k++) begin
            tick(1);
            checks++;
            if (state !== 3'd0) begin
                errors++;
                $display("FAIL loss_reset_hold k=%0d got=%0d exp=0", k, state);
            end
        end
        tick(1);
        checks++;
        if (state !== 3'd1) begin
            errors++;
            $display("FAIL loss_wait_lock got=%0d exp=1", state);
        end
    endtask

    task automatic test_relock();
        int n;
        start_bringup(1'b1);
        tick(16);
        lock = 1'b0;
        tick(2);
        relock_req = 1'b1;
        tick(1);
        relock_req = 1'b0;
        n = 0;
        for (int k = 0; k < 10; k++) begin
            if (state === 3'd0) n++;
            tick(1);
        end
        checks++;
        if (n != 4) begin
            errors++;
            $display("FAIL relock_run_single reset_cycles=%0d exp=4", n);
        end

        start_bringup(1'b0);
        tick(72);
        checks++;
        if (state !== 3'd5 || retry_cnt !== 4'd2) begin
            errors++;
            $display("FAIL relock_in_fail st=%0d rc=%0d exp st=5 rc=2", state, retry_cnt);
        end
        lock       = 1'b1;
        relock_req = 1'b1;
        tick(1);
        relock_req = 1'b0;
        checks++;
        if (state !== 3'd0 || retry_cnt !== 4'd0 || fail !== 1'b0) begin
            errors++;
            $display("FAIL relock_from_fail st=%0d rc=%0d fail=%b exp 0/0/0",
                     state, retry_cnt, fail);
        end
        tick(14);
        checks++;
        if (ready !== 1'b0) begin
            errors++;
            $display("FAIL relock_fail_pre_ready got=%b exp=0", ready);
        end
        tick(1);
        checks++;
        if (ready !== 1'b1 || retry_cnt !== 4'd0) begin
            errors++;
            $display("FAIL relock_fail_ready rdy=%b rc=%0d exp 1/0", ready, retry_cnt);
        end

        start_bringup(1'b1);
        tick(7);
        relock_req = 1'b1;
        tick(1);
        relock_req = 1'b0;
        checks++;
        if (state !== 3'd2) begin
            errors++;
            $display("FAIL relock_stable_ignored got=%0d exp=2", state);
        end
        tick(7);
        checks++;
        if (ready !== 1'b1) begin
            errors++;
            $display("FAIL relock_stable_ready got=%b exp=1", ready);
        end
    endtask

    task automatic test_reset_mid_enable();
        start_bringup(1'b1);
        tick(13);
        checks++;
        if (state !== 3'd3 || pll_clkout0en !== 1'b1) begin
            errors++;
            $display("FAIL rme_in_enable st=%0d en=%b exp 3/1", state, pll_clkout0en);
        end
        reset = 1'b1;
        tick(1);
        checks++;
        if (state !== 3'd0 || retry_cnt !== 4'd0 ||
            {pll_resetn, pll_clkout0en, sys_rst, ready, fail} !== 5'b00100) begin
            errors++;
            $display("FAIL rme_reset st=%0d rc=%0d outs=%b exp 0/0/00100", state, retry_cnt,
                     {pll_resetn, pll_clkout0en, sys_rst, ready, fail});
        end
        reset = 1'b0;
        tick(14);
        checks++;
        if (state !== 3'd3 || ready !== 1'b0) begin
            errors++;
            $display("FAIL rme_rebring_enable st=%0d rdy=%b exp 3/0", state, ready);
        end
        tick(1);
        checks++;
        if (state !== 3'd4 || ready !== 1'b1) begin
            errors++;
            $display("FAIL rme_rebring_ready st=%0d rdy=%b exp 4/1", state, ready);
        end
    endtask

    initial begin
        reset      = 1'b1;
        lock       = 1'b0;
        relock_req = 1'b0;
        test_reset();
        test_happy_path();
        test_lock_glitch();
        test_timeout_fail();
        test_loss_in_run();
        test_relock();
        test_reset_mid_enable();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/pll_reset_sequencer.md
# pll_reset_sequencer

Controls the PLL wrapper from the fabric side and sequences reset for the logic that runs from its output clock. Drives the PLL's `resetn` and `clkout0en` inputs and monitors its asynchronous `lock` output. Holds downstream logic in reset until lock has been stable for a programmed time and the output clock has been gated on. Runs on the PLL's reference clock `clkin`, in front of `PLL40` in the top level.

## Interface
- `RESET_CYCLES`, default 16: cycles `pll_resetn` is held low per reset attempt.
- `LOCK_TIMEOUT`, default 4096: cycles allowed in WAIT_LOCK before a retry.
- `STABLE_CYCLES`, default 256: cycles `lock` must stay high continuously before enabling the clock.
- `ENABLE_CYCLES`, default 8: cycles between `pll_clkout0en` rising and `sys_rst` falling.
- `MAX_RETRIES`, default 3: number of lock timeouts tolerated before FAIL.
- `CNT_W`, default 16: phase counter width. Must hold every cycle parameter minus 1.
- `clkin`, in, 1: reference clock. This is the only clock in the block.
- `reset`, in, 1: synchronous, active-high reset.
- `lock`, in, 1: PLL lock. Asynchronous to `clkin`.
- `relock_req`, in, 1: single-cycle request to re-lock the PLL. Honoured only in RUN and FAIL.
- `pll_resetn`, out, 1: drives the PLL `resetn` input (active-low).
- `pll_clkout0en`, out, 1: drives the PLL `clkout0en` input.
- `sys_rst`, out, 1: active-high reset for the PLL clock domain. Downstream logic synchronizes it locally.
- `ready`, out, 1: high only in RUN.
- `fail`, out, 1: high only in FAIL.
- `state`, out, 3: current state encoding, for debug.
- `retry_cnt`, out, 4: number of lock timeouts in the current bring-up. Saturates at 15.

## Operation
- `lock` passes through a 2-flop synchronizer; the result is `lock_s`. All decisions use `lock_s` only.
- All outputs are registered and decoded from the state register. No combinational path exists from any input to any output.
- Each state has one phase counter `cnt`. `cnt` clears on every state entry. A state with parameter P lasts exactly P cycles (exit when `cnt == P-1`).
- States and encodings:
  - RESET_PLL = 0: `pll_resetn=0`, `pll_clkout0en=0`, `sys_rst=1`. After RESET_CYCLES cycles, go to WAIT_LOCK.
  - WAIT_LOCK = 1: `pll_resetn=1`.
    - `lock_s=1` → go to STABLE.
    - Else, at `cnt == LOCK_TIMEOUT-1`: if `retry_cnt == MAX_RETRIES`, go to FAIL. Otherwise increment `retry_cnt` and go to RESET_PLL.
  - STABLE = 2:
    - `lock_s=0` → return to WAIT_LOCK. This does not count as a retry, and the timeout restarts.
    - After STABLE_CYCLES cycles with `lock_s` high, go to ENABLE.
  - ENABLE = 3: `pll_clkout0en=1`, `sys_rst=1`.
    - `lock_s=0` → go to RESET_PLL.
    - After ENABLE_CYCLES cycles, go to RUN.
  - RUN = 4: `pll_clkout0en=1`, `sys_rst=0`, `ready=1`. `retry_cnt` clears on entry.
    - `lock_s=0` or `relock_req` → go to RESET_PLL.
  - FAIL = 5: `pll_resetn=0`, `pll_clkout0en=0`, `sys_rst=1`, `fail=1`.
    - `relock_req` clears `retry_cnt` and goes to RESET_PLL.
    - Otherwise FAIL is held indefinitely.
- Simultaneous events:
  - Lock loss and `relock_req` together in RUN: single transition to RESET_PLL.
  - `lock_s` high on the timeout cycle in WAIT_LOCK: lock wins, go to STABLE.
- `relock_req` in any state other than RUN or FAIL is ignored.
- Encodings 6 and 7 are illegal and recover to RESET_PLL on the next cycle.

## Timing
- Reset values while `reset=1`: state=RESET_PLL, `cnt=0`, `retry_cnt=0`, synchronizer flops = 0, `pll_resetn=0`, `pll_clkout0en=0`, `sys_rst=1`, `ready=0`, `fail=0`.
- Reset asserted mid-operation takes effect at the next edge, whatever the current state.
- Lock latency: a `lock` edge is visible in `lock_s` 2 edges later. The state changes on the edge after that.
- Lock loss in RUN: `sys_rst=1`, `ready=0`, `pll_clkout0en=0` and `pll_resetn=0` all change together, 3 edges after `lock` falls.
- Minimum bring-up time, with lock present at `lock_s` on WAIT_LOCK entry: RESET_CYCLES + 1 + STABLE_CYCLES + ENABLE_CYCLES cycles from reset release to `ready=1`.

## Test plan
All scenarios use RESET_CYCLES=4, LOCK_TIMEOUT=20, STABLE_CYCLES=8, ENABLE_CYCLES=2, MAX_RETRIES=2.

- **Happy path.** Reset released at cycle 0, `lock` high from cycle 0 → `pll_resetn` is 0 for cycles 0–3; STABLE entered at cycle 5; `pll_clkout0en` rises at cycle 13; `sys_rst` falls and `ready` rises at cycle 15.
- **Lock glitch in STABLE.** `lock` drops for 1 cycle midway through STABLE → return to WAIT_LOCK; `retry_cnt` stays 0; `ready` rises only after a full new window of 8 stable cycles plus 2 enable cycles.
- **Timeout to FAIL.** `lock` held low → three WAIT_LOCK windows of 20 cycles each; `retry_cnt` goes 1, then 2; FAIL entered with `fail=1`, `pll_resetn=0`; state held for 100 further cycles.
- **Loss in RUN.** `lock` falls while in RUN → exactly 3 edges later `sys_rst=1`, `ready=0`, `pll_clkout0en=0`, `pll_resetn=0`; the next 4 cycles are in RESET_PLL.
- **Relock request.** `relock_req` pulsed in RUN together with a lock loss → one RESET_PLL entry. `relock_req` pulsed in FAIL → `retry_cnt=0` and RESET_PLL entered. `relock_req` pulsed in STABLE → no effect.
- **Reset mid-ENABLE.** `reset` asserted for 1 cycle during ENABLE → on the next edge, all outputs return to their reset values; a full bring-up then repeats.
